// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch and data ports.
// Optional stall performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int LAT         = 2,
    parameter int MAX_DSTREAK = 4,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic [31:0]   dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          stall_f,
    output logic          stall_m
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_fstall,
    output logic [31:0]   perf_mstall
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] LAT_C  = 4'(LAT);
    localparam logic [3:0] MAXD_C = 4'(MAX_DSTREAK);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_streak;

    logic w_if_elig;
    logic w_dm_elig;
    logic w_grant_d;
    logic w_grant_i;

    // A port that is completing this cycle may not be re-granted on the next edge.
    assign w_if_elig = if_req & ~if_ready;
    assign w_dm_elig = dm_req & ~dm_ready;
    assign w_grant_d = w_dm_elig & (~w_if_elig | (r_streak != MAXD_C));
    assign w_grant_i = w_if_elig & ~w_grant_d;

    assign stall_f = if_req & ~if_ready;
    assign stall_m = dm_req & ~dm_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_streak  <= 4'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        r_cnt     <= LAT_C;
                        r_state   <= BUSY_D;
                        // Streak only grows while fetch is actually waiting.
                        if (!if_req)
                            r_streak <= 4'd0;
                        else if (r_streak != MAXD_C)
                            r_streak <= r_streak + 4'd1;
                    end else if (w_grant_i) begin
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        r_cnt    <= LAT_C;
                        r_state  <= BUSY_I;
                        r_streak <= 4'd0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= IDLE;
                        if (r_state == BUSY_I) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if (!mem_we)
                                dm_rdata <= mem_rdata;
                            dm_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fstall <= 32'd0;
            perf_mstall <= 32'd0;
        end else begin
            if (stall_f)
                perf_fstall <= perf_fstall + 32'd1;
            if (stall_m)
                perf_mstall <= perf_mstall + 32'd1;
        end
    end
`else
    // Stall counters are not present in this build.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int MAXD = 4;
    localparam int AW   = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [31:0]   dm_wdata = 32'd0;
    logic [31:0]   dm_rdata;
    logic          dm_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;
    logic          stall_f;
    logic          stall_m;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_fstall;
    logic [31:0]   perf_mstall;
`endif

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LAT(LAT), .MAX_DSTREAK(MAXD), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
`ifdef MEM_ARB_PERF_EN
        , .perf_fstall(perf_fstall), .perf_mstall(perf_mstall)
`endif
    );

    // Reference model: an access granted at cycle c completes LAT cycles later;
    // the arbiter is free again once it completes.
    logic [31:0]   m_cyc, m_done_at;
    logic          m_busy, m_owner_d;
    int            m_streak;
    logic          e_mem_en, e_mem_we, e_if_ready, e_dm_ready;
    logic [AW-1:0] e_mem_addr;
    logic [31:0]   e_mem_wdata, e_if_rdata, e_dm_rdata, e_pf, e_pm;

    wire f_elig = if_req && !e_if_ready;
    wire d_elig = dm_req && !e_dm_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0; m_done_at <= 0; m_busy <= 0; m_owner_d <= 0; m_streak <= 0;
            e_mem_en <= 0; e_mem_we <= 0; e_mem_addr <= '0; e_mem_wdata <= 0;
            e_if_ready <= 0; e_dm_ready <= 0; e_if_rdata <= 0; e_dm_rdata <= 0;
            e_pf <= 0; e_pm <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            e_mem_en <= 0; e_if_ready <= 0; e_dm_ready <= 0;
            e_pf <= e_pf + ((if_req && !e_if_ready) ? 32'd1 : 32'd0);
            e_pm <= e_pm + ((dm_req && !e_dm_ready) ? 32'd1 : 32'd0);
            if (m_busy) begin
                if (m_cyc == m_done_at) begin
                    m_busy <= 0;
                    if (m_owner_d) begin
                        e_dm_ready <= 1;
                        if (!e_mem_we) e_dm_rdata <= mem_rdata;
                    end else begin
                        e_if_ready <= 1;
                        e_if_rdata <= mem_rdata;
                    end
                end
            end else if (f_elig || d_elig) begin
                e_mem_en <= 1; m_busy <= 1; m_done_at <= m_cyc + LAT;
                if (d_elig && (!f_elig || m_streak < MAXD)) begin
                    m_owner_d <= 1; e_mem_we <= dm_we; e_mem_addr <= dm_addr; e_mem_wdata <= dm_wdata;
                    m_streak <= !if_req ? 0 : ((m_streak + 1 > MAXD) ? MAXD : m_streak + 1);
                end else begin
                    m_owner_d <= 0; e_mem_we <= 0; e_mem_addr <= if_addr; m_streak <= 0;
                end
            end
        end
    end

    task automatic test_reset;
        if_req = 0; dm_req = 0; rst = 1;
        @(posedge clk); #1;
        nchk++; if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0) begin
            nerr++; $display("FAIL reset_ctrl: got %b want 0000", {mem_en, mem_we, if_ready, dm_ready}); end
        nchk++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
            nerr++; $display("FAIL reset_data: got %h %h %h %h want all zero", mem_addr, mem_wdata, if_rdata, dm_rdata); end
        nchk++; if ({stall_f, stall_m} !== 2'b00) begin
            nerr++; $display("FAIL reset_stall: got %b want 00", {stall_f, stall_m}); end
`ifdef MEM_ARB_PERF_EN
        nchk++; if ({perf_fstall, perf_mstall} !== 64'd0) begin
            nerr++; $display("FAIL reset_perf: got %0d %0d want 0 0", perf_fstall, perf_mstall); end
`endif
        rst = 0;
    endtask

    task automatic test_single_fetch;
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h40; mem_rdata = 32'h1111_2222; #1;
        nchk++; if (stall_f !== 1'b1) begin nerr++; $display("FAIL f1_stall_req: got %b want 1", stall_f); end
        @(posedge clk); #1;
        nchk++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
            nerr++; $display("FAIL f1_grant: got en=%b we=%b addr=%h want 1 0 00000040", mem_en, mem_we, mem_addr); end
        mem_rdata = 32'h8C01_0004;
        @(posedge clk); #1;
        nchk++; if ({mem_en, if_ready, stall_f} !== 3'b001) begin
            nerr++; $display("FAIL f1_busy: got en,rdy,stall=%b want 001", {mem_en, if_ready, stall_f}); end
        @(posedge clk); #1;
        nchk++; if ({if_ready, stall_f} !== 2'b10 || if_rdata !== 32'h8C01_0004) begin
            nerr++; $display("FAIL f1_done: got rdy,stall=%b rdata=%h want 10 8c010004", {if_ready, stall_f}, if_rdata); end
        if_req = 0;
        @(posedge clk); #1;
        nchk++; if ({if_ready, mem_en} !== 2'b00 || if_rdata !== 32'h8C01_0004) begin
            nerr++; $display("FAIL f1_after: got rdy,en=%b rdata=%h want 00 8c010004", {if_ready, mem_en}, if_rdata); end
`ifdef MEM_ARB_PERF_EN
        nchk++; if (perf_fstall !== 32'd3 || perf_mstall !== 32'd0) begin
            nerr++; $display("FAIL f1_perf: got %0d %0d want 3 0", perf_fstall, perf_mstall); end
`endif
    endtask

    task automatic test_data_priority;
        if_req = 1; if_addr = 32'h80;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h1234_5678;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                nchk++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin
                    nerr++; $display("FAIL pri_data_grant: got en=%b we=%b addr=%h wdata=%h want 1 1 00000100 deadbeef",
                                     mem_en, mem_we, mem_addr, mem_wdata); end
            end
            if (k == 4) begin
                nchk++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h80}) begin
                    nerr++; $display("FAIL pri_fetch_grant: got en=%b we=%b addr=%h want 1 0 00000080", mem_en, mem_we, mem_addr); end
            end
            nchk++; if ({dm_ready, if_ready} !== {k == 3, k == 6}) begin
                nerr++; $display("FAIL pri_ready k=%0d: got dm,if=%b want %b", k, {dm_ready, if_ready}, {k == 3, k == 6}); end
            if (k == 3) begin
                nchk++; if (dm_rdata !== 32'd0) begin nerr++; $display("FAIL pri_store_rdata: got %h want 00000000", dm_rdata); end
                dm_req = 0;
            end
            if (k == 6) begin
                nchk++; if (if_rdata !== 32'h1234_5678) begin nerr++; $display("FAIL pri_if_rdata: got %h want 12345678", if_rdata); end
                if_req = 0;
            end
        end
    endtask

    task automatic test_streak;
        int n = 0, cyc = 0;
        bit reraise = 0, fdone = 0;
        bit kinds[8];
        test_reset();
        mem_rdata = 32'h0BAD_CAFE;
        if_addr = 32'h44; dm_we = 0; dm_addr = 32'h300; dm_req = 1; if_req = 1;
        while (n < 6 && cyc < 80) begin
            @(posedge clk); #1; cyc++;
            if (mem_en) begin kinds[n] = (mem_addr == 32'h44); n++; end
            if (reraise) begin if_req = 1; reraise = 0; end
            if (dm_ready) begin
                dm_addr = 32'h300 + 32'(n) * 4;
                if (!fdone) begin if_req = 0; reraise = 1; end
            end
            if (if_ready) begin if_req = 0; fdone = 1; end
        end
        nchk++; if (n != 6) begin nerr++; $display("FAIL streak_timeout: got %0d grants want 6", n); end
        for (int i = 0; i < 6; i++) begin
            nchk++; if (kinds[i] !== (i == 4)) begin
                nerr++; $display("FAIL streak_grant%0d: got fetch=%b want %b", i, kinds[i], i == 4); end
        end
        cyc = 0;
        while (!dm_ready && cyc < 10) begin @(posedge clk); #1; cyc++; end
        nchk++; if (!dm_ready) begin nerr++; $display("FAIL streak_drain: got dm_ready=0 want 1"); end
        dm_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access;
        dm_req = 1; dm_we = 0; dm_addr = 32'h200; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        nchk++; if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin
            nerr++; $display("FAIL rstmid_grant: got en=%b addr=%h want 1 00000200", mem_en, mem_addr); end
        @(posedge clk); #3; rst = 1; #1;
        nchk++; if ({mem_en, dm_ready, mem_addr} !== '0) begin
            nerr++; $display("FAIL rstmid_abort: got en=%b rdy=%b addr=%h want 0 0 0", mem_en, dm_ready, mem_addr); end
        #1; rst = 0;
        @(posedge clk); #1;
        nchk++; if (dm_ready !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h200) begin
            nerr++; $display("FAIL rstmid_regrant: got rdy=%b en=%b addr=%h want 0 1 00000200", dm_ready, mem_en, mem_addr); end
        mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        nchk++; if (dm_ready !== 1'b0) begin nerr++; $display("FAIL rstmid_early: got dm_ready=1 want 0"); end
        @(posedge clk); #1;
        nchk++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hCAFE_F00D) begin
            nerr++; $display("FAIL rstmid_done: got rdy=%b rdata=%h want 1 cafef00d", dm_ready, dm_rdata); end
        dm_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_random_traffic;
        logic [2*AW+4*32+6-1:0] got, exp;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            got = {mem_en, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, if_rdata, dm_rdata,
                   stall_f, stall_m, if_addr ^ if_addr};
            exp = {e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata, e_if_ready, e_dm_ready, e_if_rdata, e_dm_rdata,
                   if_req & ~e_if_ready, dm_req & ~e_dm_ready, {AW{1'b0}}};
            nchk++; if (got !== exp) begin
                nerr++; if (nerr < 20) $display("FAIL rnd_outputs cyc %0d: got %h want %h", i, got, exp); end
            nchk++; if (if_ready && dm_ready) begin
                nerr++; $display("FAIL rnd_coincident cyc %0d: got both ready want at most one", i); end
`ifdef MEM_ARB_PERF_EN
            nchk++; if (perf_fstall !== e_pf || perf_mstall !== e_pm) begin
                nerr++; if (nerr < 20) $display("FAIL rnd_perf cyc %0d: got %0d %0d want %0d %0d", i, perf_fstall, perf_mstall, e_pf, e_pm); end
`endif
            mem_rdata = $urandom;
            if (if_req && if_ready) begin
                if_req = ($urandom_range(0, 1) == 1); if_addr = $urandom;
            end else if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
            end else if ($urandom_range(0, 7) == 0) begin
                if_addr = $urandom;
            end else if (dm_ready && $urandom_range(0, 1) == 0) begin
                if_req = 0;
            end
            if (dm_req && dm_ready) begin
                dm_req = ($urandom_range(0, 1) == 1); dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
            end else if (!dm_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    dm_req = 1; dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                dm_addr = $urandom;
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_fetch();
        test_data_priority();
        test_streak();
        test_reset_mid_access();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
